axi_mem_bw_limiter: RTL and testbench

AXI_MEM_BW_LIMITER -- requirements
Module: axi_mem_bw_limiter

---
 rtl/axi_mem_bw_limiter_pkg.sv | 33 +++
 rtl/axi_mem_bw_limiter_if.sv | 35 +++
 rtl/axi_mem_bw_limiter_bucket.sv | 46 ++++
 rtl/axi_mem_bw_limiter.sv | 129 ++++++++++++
 tb/tb_axi_mem_bw_limiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_bw_limiter_pkg.sv
// rtl/axi_mem_bw_limiter_pkg.sv - shared types, widths and cost helper for the AXI bandwidth limiter
package bw_limiter_pkg;
  localparam int TOKEN_W = 16;
  localparam int COST_W  = 9;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int ID_W    = 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FWD_AR = 2'd1, FWD_AW = 2'd2} state_e;
  typedef enum logic {GRANT_AR = 1'b0, GRANT_AW = 1'b1} grant_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } ax_beat_t;

  // Beats in the burst, clamped to the bucket size so an oversize burst can still drain a full bucket.
  function automatic logic [COST_W-1:0] beat_cost(input logic [7:0] len, input logic en,
                                                  input logic [TOKEN_W-1:0] cap);
    logic [COST_W-1:0] raw;
    raw = {1'b0, len} + COST_W'(1);
    if (!en) beat_cost = '0;
    else if (TOKEN_W'(raw) > cap) beat_cost = cap[COST_W-1:0];
    else beat_cost = raw;
  endfunction
endpackage

// File: rtl/axi_mem_bw_limiter_if.sv
// rtl/axi_mem_bw_limiter_if.sv - AXI4 bus bundle, 64-bit data, 1-bit ID, all five channels
interface axi_mem_bw_limiter_if;
  import bw_limiter_pkg::*;

  logic [ID_W-1:0]   awid;   logic [ADDR_W-1:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]        awburst; logic awlock; logic [3:0] awcache; logic [2:0] awprot; logic [3:0] awqos;
  logic              awvalid; logic awready;
  logic [DATA_W-1:0] wdata;  logic [DATA_W/8-1:0] wstrb; logic wlast; logic wvalid; logic wready;
  logic [ID_W-1:0]   bid;    logic [1:0] bresp; logic bvalid; logic bready;
  logic [ID_W-1:0]   arid;   logic [ADDR_W-1:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]        arburst; logic arlock; logic [3:0] arcache; logic [2:0] arprot; logic [3:0] arqos;
  logic              arvalid; logic arready;
  logic [ID_W-1:0]   rid;    logic [DATA_W-1:0] rdata; logic [1:0] rresp; logic rlast; logic rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_mem_bw_limiter_bucket.sv
// rtl/axi_mem_bw_limiter_bucket.sv - token bucket: tokens, refill counter, saturation, eligibility
module bw_token_bucket
  import bw_limiter_pkg::*;
#(
  parameter int BUCKET_MAX    = 64,
  parameter int REFILL_PERIOD = 16,
  parameter int REFILL_AMT    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [COST_W-1:0] ar_cost_i,
  input  logic [COST_W-1:0] aw_cost_i,
  input  logic [COST_W-1:0] deduct_i,
  output logic              ar_ok_o,
  output logic              aw_ok_o
);
  localparam int XW = TOKEN_W + 1;
  localparam logic [TOKEN_W-1:0] MAX_T    = TOKEN_W'(BUCKET_MAX);
  localparam logic [XW-1:0]      MAX_X    = XW'(BUCKET_MAX);
  localparam logic [XW-1:0]      AMT_X    = XW'(REFILL_AMT);
  localparam logic [TOKEN_W-1:0] LAST_CNT = TOKEN_W'(REFILL_PERIOD - 1);

  logic [TOKEN_W-1:0] tokens_q, tokens_d, cnt_q, cnt_d;
  logic               refill;
  logic [XW-1:0]      sum;

  // One extra bit keeps a same-cycle deduct and refill exact before saturating.
  always_comb begin
    refill   = (cnt_q == LAST_CNT);
    cnt_d    = refill ? '0 : cnt_q + TOKEN_W'(1);
    sum      = {1'b0, tokens_q} - XW'(deduct_i) + (refill ? AMT_X : '0);
    tokens_d = (sum > MAX_X) ? MAX_T : sum[TOKEN_W-1:0];
    ar_ok_o  = (TOKEN_W'(ar_cost_i) <= tokens_q);
    aw_ok_o  = (TOKEN_W'(aw_cost_i) <= tokens_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tokens_q <= MAX_T;
      cnt_q    <= '0;
    end else begin
      tokens_q <= tokens_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_mem_bw_limiter.sv
// rtl/axi_mem_bw_limiter.sv - token-bucket AR/AW rate limiter; BW_LIMIT_STATS_EN adds stall/beat counters
module axi_mem_bw_limiter
  import bw_limiter_pkg::*;
#(
  parameter int BUCKET_MAX    = 64,
  parameter int REFILL_PERIOD = 16,
  parameter int REFILL_AMT    = 4
) (
  input  logic                 uncoreclk,
  input  logic                 uncorerst,
  input  logic                 limit_en,
  axi_mem_bw_limiter_if.slave  s_axi,
  axi_mem_bw_limiter_if.master m_axi
`ifdef BW_LIMIT_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          beat_cnt
`endif
);
  state_e            state_q, state_d;
  grant_e            last_q, last_d;
  ax_beat_t          hold_q, hold_d, s_ar, s_aw;
  logic [COST_W-1:0] ar_cost, aw_cost, deduct;
  logic              ar_ok, aw_ok, ar_elig, aw_elig, idle, pick_ar, pick_aw;

  assign ar_cost = beat_cost(s_axi.arlen, limit_en, TOKEN_W'(BUCKET_MAX));
  assign aw_cost = beat_cost(s_axi.awlen, limit_en, TOKEN_W'(BUCKET_MAX));

  assign s_ar = '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen, size: s_axi.arsize,
                  burst: s_axi.arburst, lock: s_axi.arlock, cache: s_axi.arcache,
                  prot: s_axi.arprot, qos: s_axi.arqos};
  assign s_aw = '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen, size: s_axi.awsize,
                  burst: s_axi.awburst, lock: s_axi.awlock, cache: s_axi.awcache,
                  prot: s_axi.awprot, qos: s_axi.awqos};

  bw_token_bucket #(
    .BUCKET_MAX(BUCKET_MAX), .REFILL_PERIOD(REFILL_PERIOD), .REFILL_AMT(REFILL_AMT)
  ) u_bucket (
    .clk_i(uncoreclk), .rst_i(uncorerst), .ar_cost_i(ar_cost), .aw_cost_i(aw_cost),
    .deduct_i(deduct), .ar_ok_o(ar_ok), .aw_ok_o(aw_ok)
  );

  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      state_q <= IDLE;
      last_q  <= GRANT_AW;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // AR wins a tie unless it took the previous grant.
  always_comb begin
    idle    = (state_q == IDLE) && !uncorerst;
    ar_elig = s_axi.arvalid && ar_ok;
    aw_elig = s_axi.awvalid && aw_ok;
    pick_ar = idle && ar_elig && (!aw_elig || last_q == GRANT_AW);
    pick_aw = idle && aw_elig && !pick_ar;
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    deduct  = '0;
    case (state_q)
      IDLE: begin
        if (pick_ar) begin
          state_d = FWD_AR; last_d = GRANT_AR; hold_d = s_ar; deduct = ar_cost;
        end else if (pick_aw) begin
          state_d = FWD_AW; last_d = GRANT_AW; hold_d = s_aw; deduct = aw_cost;
        end
      end
      FWD_AR:  if (m_axi.arready) state_d = IDLE;
      FWD_AW:  if (m_axi.awready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = pick_ar;
    s_axi.awready = pick_aw;
    m_axi.arvalid = (state_q == FWD_AR) && !uncorerst;
    m_axi.awvalid = (state_q == FWD_AW) && !uncorerst;
    m_axi.arid    = hold_q.id;    m_axi.awid    = hold_q.id;
    m_axi.araddr  = hold_q.addr;  m_axi.awaddr  = hold_q.addr;
    m_axi.arlen   = hold_q.len;   m_axi.awlen   = hold_q.len;
    m_axi.arsize  = hold_q.size;  m_axi.awsize  = hold_q.size;
    m_axi.arburst = hold_q.burst; m_axi.awburst = hold_q.burst;
    m_axi.arlock  = hold_q.lock;  m_axi.awlock  = hold_q.lock;
    m_axi.arcache = hold_q.cache; m_axi.awcache = hold_q.cache;
    m_axi.arprot  = hold_q.prot;  m_axi.awprot  = hold_q.prot;
    m_axi.arqos   = hold_q.qos;   m_axi.awqos   = hold_q.qos;
  end

  assign m_axi.wdata  = s_axi.wdata;
  assign m_axi.wstrb  = s_axi.wstrb;
  assign m_axi.wlast  = s_axi.wlast;
  assign m_axi.wvalid = s_axi.wvalid;
  assign s_axi.wready = m_axi.wready;
  assign s_axi.bid    = m_axi.bid;
  assign s_axi.bresp  = m_axi.bresp;
  assign s_axi.bvalid = m_axi.bvalid;
  assign m_axi.bready = s_axi.bready;
  assign s_axi.rid    = m_axi.rid;
  assign s_axi.rdata  = m_axi.rdata;
  assign s_axi.rresp  = m_axi.rresp;
  assign s_axi.rlast  = m_axi.rlast;
  assign s_axi.rvalid = m_axi.rvalid;
  assign m_axi.rready = s_axi.rready;

`ifdef BW_LIMIT_STATS_EN
  logic [31:0] stall_q, beat_q;

  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      stall_q <= '0;
      beat_q  <= '0;
    end else begin
      if (state_q == IDLE && ((s_axi.arvalid && !ar_ok) || (s_axi.awvalid && !aw_ok)))
        stall_q <= stall_q + 32'd1;
      beat_q <= beat_q + 32'(deduct);
    end
  end

  assign stall_cnt = stall_q;
  assign beat_cnt  = beat_q;
`endif
endmodule

// File: tb/tb_axi_mem_bw_limiter.sv
// tb/tb_axi_mem_bw_limiter.sv - directed self-checking bench for axi_mem_bw_limiter
module tb_axi_mem_bw_limiter;
  import bw_limiter_pkg::*;

  localparam int P = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic limit_en = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  axi_mem_bw_limiter_if s_if();
  axi_mem_bw_limiter_if m_if();

`ifdef BW_LIMIT_STATS_EN
  logic [31:0] stall_cnt, beat_cnt;
`endif

  axi_mem_bw_limiter #(.BUCKET_MAX(64), .REFILL_PERIOD(P), .REFILL_AMT(4)) dut (
    .uncoreclk(clk), .uncorerst(rst), .limit_en(limit_en), .s_axi(s_if), .m_axi(m_if)
`ifdef BW_LIMIT_STATS_EN
    , .stall_cnt(stall_cnt), .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = 3'd3; s_if.awburst = 2'd1;
    s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awvalid = 1'b0;
    s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = 3'd3; s_if.arburst = 2'd1;
    s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0; s_if.arvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    m_if.awready = 1'b1; m_if.arready = 1'b1; m_if.wready = 1'b1;
    m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
    m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    limit_en = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    s_if.arvalid = 1'b1; s_if.awvalid = 1'b1;
    s_if.wvalid = 1'b1; s_if.wdata = 64'hDEAD_BEEF_0123_4567; s_if.wlast = 1'b1;
    m_if.wready = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 64'h0BAD_F00D_CAFE_0001;
    tick(); tick();
    @(negedge clk);
    checks++; if (s_if.arready !== 1'b0 || s_if.awready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got ar=%b aw=%b want 0 0", s_if.arready, s_if.awready); end
    checks++; if (m_if.arvalid !== 1'b0 || m_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mvalid got ar=%b aw=%b want 0 0", m_if.arvalid, m_if.awvalid); end
    checks++; if (dut.u_bucket.tokens_q !== 16'd64) begin
      errors++; $display("FAIL rst_tokens got %0d want 64", dut.u_bucket.tokens_q); end
    checks++; if (m_if.wvalid !== 1'b1 || m_if.wdata !== 64'hDEAD_BEEF_0123_4567 || s_if.wready !== 1'b0) begin
      errors++; $display("FAIL rst_w_pass got v=%b d=%h r=%b want 1 deadbeef01234567 0", m_if.wvalid, m_if.wdata, s_if.wready); end
    checks++; if (s_if.rvalid !== 1'b1 || s_if.rdata !== 64'h0BAD_F00D_CAFE_0001) begin
      errors++; $display("FAIL rst_r_pass got v=%b d=%h want 1 0badf00dcafe0001", s_if.rvalid, s_if.rdata); end
    tick();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_w_before_aw();
    do_reset();
    s_if.wvalid = 1'b1; s_if.wdata = 64'h1122_3344_5566_7788; s_if.wstrb = 8'hF0; s_if.wlast = 1'b1;
    @(negedge clk);
    checks++; if (m_if.wvalid !== 1'b1 || m_if.wdata !== 64'h1122_3344_5566_7788 || m_if.wstrb !== 8'hF0 || m_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL w_first got v=%b d=%h s=%h awv=%b want 1 1122334455667788 f0 0", m_if.wvalid, m_if.wdata, m_if.wstrb, m_if.awvalid); end
    tick();
  endtask

  task automatic test_ar_latency();
    do_reset();
    s_if.arvalid = 1'b1; s_if.arlen = 8'd7; s_if.araddr = 32'h1000_0040; s_if.arid = 1'b1;
    @(negedge clk);
    checks++; if (s_if.arready !== 1'b1) begin
      errors++; $display("FAIL ar_ready got %b want 1", s_if.arready); end
    tick();
    s_if.arvalid = 1'b0;
    @(negedge clk);
    checks++; if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h1000_0040 || m_if.arlen !== 8'd7 || m_if.arid !== 1'b1) begin
      errors++; $display("FAIL ar_fwd got v=%b a=%h l=%0d id=%b want 1 10000040 7 1", m_if.arvalid, m_if.araddr, m_if.arlen, m_if.arid); end
    checks++; if (dut.u_bucket.tokens_q !== 16'd56) begin
      errors++; $display("FAIL ar_tokens got %0d want 56", dut.u_bucket.tokens_q); end
    tick();
    @(negedge clk);
    checks++; if (m_if.arvalid !== 1'b0) begin
      errors++; $display("FAIL ar_done got %b want 0", m_if.arvalid); end
    tick();
  endtask

  task automatic test_aw_drain();
    int g_first = 0;
    int g_early = 0;
    logic [15:0] tok200 = '0;
    do_reset();
    s_if.awvalid = 1'b1; s_if.awlen = 8'd15;
    while (cyc < 4 * P) begin
      @(negedge clk);
      if (s_if.awready) begin
        if (cyc < P - 1) g_first++;
        else g_early++;
      end
      if (cyc == P) tok200 = dut.u_bucket.tokens_q;
      tick();
    end
    checks++; if (g_first != 4) begin
      errors++; $display("FAIL aw_grants got %0d want 4", g_first); end
    checks++; if (g_early != 0) begin
      errors++; $display("FAIL aw_starved got %0d want 0", g_early); end
    checks++; if (tok200 !== 16'd4) begin
      errors++; $display("FAIL aw_refill got %0d want 4", tok200); end
    @(negedge clk);
    checks++; if (s_if.awready !== 1'b1) begin
      errors++; $display("FAIL aw_resume got %b want 1", s_if.awready); end
    tick();
    s_if.awvalid = 1'b0;
    checks++; if (dut.u_bucket.tokens_q !== 16'd0) begin
      errors++; $display("FAIL aw_tokens got %0d want 0", dut.u_bucket.tokens_q); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] seq = '0;
    int n = 0;
    int both = 0;
    do_reset();
    s_if.arvalid = 1'b1; s_if.awvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_if.arready && s_if.awready) both++;
      if (s_if.arready) begin seq[n] = 1'b0; n++; end
      else if (s_if.awready) begin seq[n] = 1'b1; n++; end
      tick();
    end
    s_if.arvalid = 1'b0; s_if.awvalid = 1'b0;
    checks++; if (n != 4 || both != 0) begin
      errors++; $display("FAIL rr_count got %0d both=%0d want 4 0", n, both); end
    checks++; if (seq[3:0] !== 4'b1010) begin
      errors++; $display("FAIL rr_order got %b want 1010", seq[3:0]); end
    checks++; if (dut.u_bucket.tokens_q !== 16'd60) begin
      errors++; $display("FAIL rr_tokens got %0d want 60", dut.u_bucket.tokens_q); end
`ifdef BW_LIMIT_STATS_EN
    checks++; if (beat_cnt !== 32'd4) begin
      errors++; $display("FAIL rr_beats got %0d want 4", beat_cnt); end
`endif
    tick();
  endtask

  task automatic test_refill_edge();
    int early = 0;
    do_reset();
    s_if.arvalid = 1'b1; s_if.arlen = 8'd61;
    tick();
    s_if.arlen = 8'd3;
    while (cyc < P) begin
      @(negedge clk);
      if (s_if.arready) early++;
      tick();
    end
    checks++; if (early != 0) begin
      errors++; $display("FAIL refill_wait got %0d grants want 0", early); end
    @(negedge clk);
    checks++; if (s_if.arready !== 1'b1) begin
      errors++; $display("FAIL refill_grant got %b want 1", s_if.arready); end
    tick();
    s_if.arvalid = 1'b0;
    checks++; if (dut.u_bucket.tokens_q !== 16'd2 || m_if.arlen !== 8'd3) begin
      errors++; $display("FAIL refill_tokens got %0d len=%0d want 2 3", dut.u_bucket.tokens_q, m_if.arlen); end
    tick();
  endtask

  task automatic test_clamp();
    int early = 0;
    do_reset();
    s_if.arvalid = 1'b1; s_if.arlen = 8'd255;
    @(negedge clk);
    checks++; if (s_if.arready !== 1'b1) begin
      errors++; $display("FAIL clamp_first got %b want 1", s_if.arready); end
    tick();
    checks++; if (dut.u_bucket.tokens_q !== 16'd0 || m_if.arlen !== 8'd255) begin
      errors++; $display("FAIL clamp_tokens got %0d len=%0d want 0 255", dut.u_bucket.tokens_q, m_if.arlen); end
    while (cyc < 16 * P) begin
      @(negedge clk);
      if (s_if.arready) early++;
      tick();
    end
    checks++; if (early != 0) begin
      errors++; $display("FAIL clamp_wait got %0d grants want 0", early); end
    @(negedge clk);
    checks++; if (s_if.arready !== 1'b1) begin
      errors++; $display("FAIL clamp_second got %b want 1", s_if.arready); end
    tick();
    s_if.arvalid = 1'b0;
    tick();
    limit_en = 1'b0;
    s_if.arvalid = 1'b1;
    @(negedge clk);
    checks++; if (s_if.arready !== 1'b1) begin
      errors++; $display("FAIL bypass_grant got %b want 1", s_if.arready); end
    tick();
    s_if.arvalid = 1'b0;
    checks++; if (dut.u_bucket.tokens_q !== 16'd0) begin
      errors++; $display("FAIL bypass_tokens got %0d want 0", dut.u_bucket.tokens_q); end
    limit_en = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_fwd();
    do_reset();
    m_if.awready = 1'b0;
    s_if.awvalid = 1'b1; s_if.awlen = 8'd3;
    tick();
    s_if.awvalid = 1'b0;
    @(negedge clk);
    checks++; if (m_if.awvalid !== 1'b1) begin
      errors++; $display("FAIL fwd_hold got %b want 1", m_if.awvalid); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL fwd_rst_valid got %b want 0", m_if.awvalid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_if.awvalid !== 1'b0 || dut.u_bucket.tokens_q !== 16'd64 || dut.state_q !== IDLE) begin
      errors++; $display("FAIL fwd_rst_state got v=%b tok=%0d st=%0d want 0 64 0", m_if.awvalid, dut.u_bucket.tokens_q, dut.state_q); end
    m_if.awready = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_w_before_aw();
    test_ar_latency();
    test_aw_drain();
    test_round_robin();
    test_refill_edge();
    test_clamp();
    test_reset_mid_fwd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
